// File: rtl/rnn_ram_loader_if.sv
// Valid/ready word stream feeding the RNN parameter/state memory loader.
interface rnn_ram_loader_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/rnn_ram_loader.sv
// Groups five stream beats into a (W,H,U,X,V) record and writes it
// to the memory with a one-cycle strobe at an auto-incrementing port.
module rnn_ram_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_port,
    input  logic [ADDR_WIDTH:0]   num_records,
    rnn_ram_loader_if.slave       s,
    output logic [DATA_WIDTH-1:0] writeW,
    output logic [DATA_WIDTH-1:0] writeH,
    output logic [DATA_WIDTH-1:0] writeU,
    output logic [DATA_WIDTH-1:0] writeX,
    output logic [DATA_WIDTH-1:0] writeV,
    output logic                  writeenable,
    output logic [ADDR_WIDTH-1:0] writeport,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [2:0]            beat;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  accept;
    logic                  last_beat;

    assign accept    = s.s_valid && s.s_ready;
    assign last_beat = (beat == 3'd4);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        s.s_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        writeenable = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = (num_records != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                s.s_ready = 1'b1;
                busy      = 1'b1;
                if (s.s_valid && last_beat) begin
                    state_n = WRITE;
                end
            end
            WRITE: begin
                busy        = 1'b1;
                writeenable = 1'b1;
                state_n = (remaining > (ADDR_WIDTH+1)'(1)) ? LOAD : DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign writeport = addr;

    // Fields only change while loading, so they stay stable through WRITE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            beat      <= '0;
            addr      <= '0;
            remaining <= '0;
            writeW    <= '0;
            writeH    <= '0;
            writeU    <= '0;
            writeX    <= '0;
            writeV    <= '0;
        end else begin
            if (state == IDLE && start) begin
                addr      <= base_port;
                remaining <= num_records;
            end
            if (accept) begin
                case (beat)
                    3'd0:    writeW <= s.s_data;
                    3'd1:    writeH <= s.s_data;
                    3'd2:    writeU <= s.s_data;
                    3'd3:    writeX <= s.s_data;
                    3'd4:    writeV <= s.s_data;
                    default: ;
                endcase
                beat <= last_beat ? 3'd0 : beat + 3'd1;
            end
            if (state == WRITE) begin
                addr      <= addr + ADDR_WIDTH'(1);
                remaining <= remaining - (ADDR_WIDTH+1)'(1);
            end
        end
    end

endmodule

// File: doc/rnn_ram_loader.md
# rnn_ram_loader

Host-side writer for the RNN parameter/state memory. It accepts a stream of 32-bit words over a valid/ready handshake and groups every five beats into one record (W, H, U, X, V). Each record is written into the memory's five-field write port with a single-cycle write strobe, and the target port address auto-increments from a programmable base. It sits between the host/DMA stream and the memory write side, which the RNN processing node reads each timestep.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each field and stream word
- ADDR_WIDTH, 4, width of memory port address (2^ADDR_WIDTH records)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset==0 on a rising edge resets all state)
- start  in  1  begin a load; sampled only in IDLE
- base_port  in  ADDR_WIDTH  first record address, captured on accepted start
- num_records  in  ADDR_WIDTH+1  records to load, captured on accepted start; 0 = no-op
- s_data  in  DATA_WIDTH  stream word
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts a word this cycle
- writeW, writeH, writeU, writeX, writeV  out  DATA_WIDTH each  staged record fields
- writeenable  out  1  one-cycle write strobe
- writeport  out  ADDR_WIDTH  write address for current strobe
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at end of load

## Operation
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE: s_ready=0, busy=0. start=1 → capture base_port into addr, num_records into remaining; next state LOAD if num_records!=0, else DONE.
- LOAD: s_ready=1, busy=1. Beat counter 0..4. Each accepted beat (s_valid&&s_ready) stores s_data into field by counter: 0→W, 1→H, 2→U, 3→X, 4→V. s_valid=0 stalls with no state change. Acceptance of beat 4 → counter clears, next state WRITE.
- WRITE: s_ready=0, busy=1, writeenable=1, writeport=addr. Next edge: addr+1 (modulo 2^ADDR_WIDTH), remaining−1; next state LOAD if remaining was >1, else DONE.
- DONE: done=1, busy=0, s_ready=0; next state IDLE unconditionally.
- write* field registers hold their last values outside WRITE; only writeenable qualifies them.
- start while not in IDLE: ignored, base_port/num_records not recaptured.
- Address wrap: base_port=2^ADDR_WIDTH−1 with 2 records writes last port then port 0.
- num_records > 2^ADDR_WIDTH permitted; addresses wrap and overwrite.

## Timing
- Reset values: state IDLE, s_ready=0, writeenable=0, writeport=0, write* fields=0, busy=0, done=0, beat counter=0, remaining=0.
- Reset mid-operation: partial record discarded, no writeenable issued, FSM to IDLE on the same edge.
- start accepted at edge k → busy=1 and s_ready=1 in cycle k+1.
- Fifth beat accepted at edge t → writeenable=1 for exactly cycle t+1 with all five fields and writeport stable in that cycle.
- With s_valid held high: 6 cycles per record (5 LOAD + 1 WRITE); N records finish with done at cycle k+1+6N.
- num_records=0: start at edge k → done=1 in cycle k+1, no writeenable, no beats accepted.
- done is high for exactly one cycle; start asserted during DONE is ignored; a new start is accepted in IDLE the following cycle.
- Beats presented while s_ready=0 are not consumed and must be held by the source.

## Test plan
- Reset: drive reset=0 for 2 cycles with random inputs → all outputs 0, s_ready=0, no writeenable.
- Single record: base_port=3, num_records=1, stream 0x11,0x22,0x33,0x44,0x55 continuously → one writeenable cycle with W=0x11,H=0x22,U=0x33,X=0x44,V=0x55, writeport=3; done 1 cycle later, 7 cycles after start edge.
- Backpressure/stall: base_port=0, num_records=2, s_valid toggling every other cycle over 10 words → two strobes at ports 0 and 1 with correct field order, no beat lost or duplicated.
- Wrap: base_port=15, num_records=2 (ADDR_WIDTH=4) → strobes at writeport 15 then 0.
- Zero count and ignored start: num_records=0 → done next cycle, no strobe; then start pulsed during LOAD of a 1-record load with base_port=5, re-pulsed with base_port=9 → write lands at 5 only.
- Reset mid-record: after 3 beats of a record, reset=0 one cycle → no writeenable, FSM IDLE, next load starts fresh at beat W.
